instruction_encoder: RTL and testbench

//  Inverse of immediate generation: packs format, opcode, register fields and a 32-bit immediate into a
//  RV32I instruction word. Sits in the self-test/trace path and feeds generated instructions into instruction memory.
//  2-stage valid/ready pipeline. Range/alignment checking is per format. Saturating statistics counters.

---
 rtl/instruction_encoder_pkg.sv | 41 ++++
 rtl/instruction_encoder_packer.sv | 27 ++
 rtl/instruction_encoder.sv | 78 +++++++
 tb/tb_instruction_encoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: RV32I format codes, opcodes and immediate range check
package instruction_encoder_pkg;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;
  // high bits must be a pure sign extension; branch/jump targets must be even
  function automatic logic imm_err(input logic [2:0] fmt, input logic [31:0] imm);
    case (fmt)
      FMT_R:        return 1'b0;
      FMT_I, FMT_S: return !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        return !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        return !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        return |imm[11:0];
      default:      return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/instruction_encoder_packer.sv
// imm_field_packer: combinational fmt + fields + immediate -> RV32I instruction word
module imm_field_packer
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr
);
  always_comb begin
    instr = '0;
    case (fmt)
      FMT_R:   instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   instr = {imm[31:12], rd, opcode};
      FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = '0;
    endcase
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: 2-stage valid/ready RV32I encoder with range check and saturating stats
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  req_t        s1_req;
  logic        s1_valid;
  logic        s1_err;
  logic        s2_open;
  logic        s1_advance;
  logic        out_hs;
  logic [31:0] packed_word;
  assign s2_open    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_open;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_hs     = out_valid && out_ready;
  imm_field_packer u_packer (
    .fmt    (s1_req.fmt),
    .opcode (s1_req.opcode),
    .rd     (s1_req.rd),
    .rs1    (s1_req.rs1),
    .rs2    (s1_req.rs2),
    .funct3 (s1_req.funct3),
    .funct7 (s1_req.funct7),
    .imm    (s1_req.imm),
    .instr  (packed_word)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_req    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_req <= '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      funct3: in_funct3, funct7: in_funct7, imm: in_imm};
          s1_err <= imm_err(in_fmt, in_imm);
        end
      end
      if (s2_open) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= packed_word;
          out_err   <= s1_err;
        end
      end
      if (out_hs && !(&enc_count)) enc_count <= enc_count + CNT_W'(1);
      if (out_hs && out_err && !(&err_count)) err_count <= err_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed checks of encoding, errors, backpressure, reset and saturation
module tb_instruction_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;
  int checks = 0;
  int errors = 0;

  instruction_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference immediate generator: recovers the immediate from an encoded word
  function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] i);
    case (fmt)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'b0};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // one request through an empty pipeline: checks latency, word, error flag and decoded immediate
  task automatic send_one(input string tag, input logic [2:0] f, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
    set_req(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid_n1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_n2"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    if (!exp_err && f != 3'd0) chk({tag, "_decode"}, decode_imm(f, out_instr), imm);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_exp [5];
  int idx_in, idx_out;
  logic prev_stall;
  logic [31:0] prev_instr;
  logic prev_err;

  initial begin
    bp_exp[0] = 32'h00000093; bp_exp[1] = 32'h00100113; bp_exp[2] = 32'h00200193;
    bp_exp[3] = 32'h00300213; bp_exp[4] = 32'h00400293;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    send_one("addi", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    send_one("beq",  3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008, 32'h00000463, 1'b0);
    send_one("jal",  3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
    send_one("lui",  3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send_one("lui_bad", 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1);
    chk("lui_bad_err_count", 32'(err_count), 32'd1);
    send_one("b_odd", 3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000003, 32'h00000163, 1'b1);
    send_one("i_range", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000093, 1'b1);
    send_one("fmt7", 3'd7, 7'b0010011, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'h00000000, 32'h00000000, 1'b1);
    send_one("sw", 3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0);
    send_one("add", 3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000000, 32'h002081B3, 1'b0);
    chk("dir_enc_count", 32'(enc_count), 32'd10);
    chk("dir_err_count", 32'(err_count), 32'd4);

    // backpressure: five addi back to back, consumer stalled for the first four cycles
    idx_in = 0; idx_out = 0; prev_stall = 1'b0; prev_instr = '0; prev_err = 1'b0;
    for (int c = 0; c < 40 && idx_out < 5; c++) begin
      out_ready = (c >= 4);
      in_valid = (idx_in < 5);
      set_req(3'd1, 7'b0010011, 5'(idx_in + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(idx_in));
      #1;
      if (c == 2) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (c == 4) chk("bp_in_ready_release", 32'(in_ready), 32'd1);
      if (prev_stall) begin
        chk("bp_stable_instr", out_instr, prev_instr);
        chk("bp_stable_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready) begin
        chk("bp_order", out_instr, bp_exp[idx_out]);
        idx_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err = out_err;
      if (in_valid && in_ready) idx_in++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_words", 32'(idx_out), 32'd5);
    chk("bp_enc_count", 32'(enc_count), 32'd15);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_req(3'd1, 7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_enc_count", 32'(enc_count), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_ghost", 32'(out_valid), 32'd0);

    // saturation: stream erroneous words past the counter range
    in_valid = 1'b1;
    set_req(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_enc_count", 32'(enc_count), 32'h0000FFFF);
    chk("sat_err_count", 32'(err_count), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
